blockmem_responder: RTL and testbench



---
 rtl/blockmem_responder.sv | 126 ++++++++++++
 tb/tb_blockmem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/blockmem_responder.sv
// Clocked block-memory slave for cache line fills and writebacks with a fixed access latency.
// Optional out-of-range detection and resp_err port: define BLOCKMEM_RANGE_CHECK_EN.
module blockmem_responder #(
  parameter int BLOCK_BITS  = 1024,
  parameter int OFFSET_BITS = 7,
  parameter int MEM_BLOCKS  = 256,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [BLOCK_BITS-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [BLOCK_BITS-1:0] resp_rdata
`ifdef BLOCKMEM_RANGE_CHECK_EN
  ,
  output logic                  resp_err
`endif
);

  localparam int IDX_W = $clog2(MEM_BLOCKS);

  // state | meaning
  // IDLE  | ready for a request
  // BUSY  | counting down the access latency
  // RESP  | single-cycle completion; writes commit on the edge leaving this state
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state, state_next;
  logic                    accept;
  logic [7:0]              cnt;
  logic                    wr_q, oor_q;
  logic [IDX_W-1:0]        idx_q;
  logic [BLOCK_BITS-1:0]   wdata_q;
  logic [BLOCK_BITS-1:0]   mem [MEM_BLOCKS];

  logic [31:0]             blk;
  logic                    oor_c;
  logic                    ld_wr, ld_oor;
  logic [IDX_W-1:0]        ld_idx;

  assign blk = req_addr >> OFFSET_BITS;

`ifdef BLOCKMEM_RANGE_CHECK_EN
  assign oor_c = (blk >= 32'(MEM_BLOCKS));
`else
  logic unused_blk_hi;
  assign oor_c         = 1'b0;
  assign unused_blk_hi = ^blk[31:IDX_W];
`endif

  // With LATENCY=1 the response follows acceptance directly, so the fill
  // read must use the live request rather than the not-yet-latched copy.
  assign ld_wr  = (state == IDLE) ? req_write        : wr_q;
  assign ld_oor = (state == IDLE) ? oor_c            : oor_q;
  assign ld_idx = (state == IDLE) ? blk[IDX_W-1:0]   : idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ~rst;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt == 8'd1) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 8'd0;
      wr_q       <= 1'b0;
      oor_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        cnt     <= 8'(LATENCY - 1);
        wr_q    <= req_write;
        oor_q   <= oor_c;
        idx_q   <= blk[IDX_W-1:0];
        wdata_q <= req_wdata;
      end else if (state == BUSY) begin
        cnt <= cnt - 8'd1;
      end
      if (state_next == RESP && state != RESP && !ld_wr)
        resp_rdata <= ld_oor ? '0 : mem[ld_idx];
    end
  end

`ifdef BLOCKMEM_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) resp_err <= 1'b0;
    else     resp_err <= (state_next == RESP) && (state != RESP) && ld_oor;
  end
`endif

  // Storage is deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (state == RESP && wr_q && !oor_q)
      mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_blockmem_responder.sv
// Scoreboard bench for blockmem_responder: latency, fill data, serialization, reset drop.
// Exercises the range-check path when BLOCKMEM_RANGE_CHECK_EN is defined, aliasing otherwise.
module tb_blockmem_responder;
  localparam int BB  = 1024;
  localparam int OB  = 7;
  localparam int MB  = 256;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [31:0]   req_addr  = '0;
  logic [BB-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [BB-1:0] resp_rdata;
  logic          resp_err;

  blockmem_responder #(.BLOCK_BITS(BB), .OFFSET_BITS(OB), .MEM_BLOCKS(MB), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata)
`ifdef BLOCKMEM_RANGE_CHECK_EN
    , .resp_err(resp_err)
`endif
  );
`ifndef BLOCKMEM_RANGE_CHECK_EN
  assign resp_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic          wr;
    int            idx;
    logic [BB-1:0] data;
    logic          err;
    int            acc;
  } txn_t;

  txn_t          sb[$];
  logic [BB-1:0] model [int];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> OB) & (MB - 1));
  endfunction

  function automatic logic err_of(input logic [31:0] a);
`ifdef BLOCKMEM_RANGE_CHECK_EN
    return (a >> OB) >= MB;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [BB-1:0] pat();
    logic [BB-1:0] p;
    for (int i = 0; i < BB/32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // Response monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    txn_t t;
    if (rst) begin
      sb.delete();
    end else begin
      if (resp_valid) begin
        check("ready_in_resp", 256'(req_ready), 256'(0));
        if (sb.size() == 0) begin
          check("spurious_resp", 256'(1), 256'(0));
        end else begin
          t = sb.pop_front();
          check("resp_latency", 256'(cyc), 256'(t.acc + LAT - 1));
`ifdef BLOCKMEM_RANGE_CHECK_EN
          check("resp_err", 256'(resp_err), 256'(t.err));
`endif
          if (!t.wr) begin
            for (int k = 0; k < BB/256; k++)
              check($sformatf("rdata_w%0d", k), resp_rdata[k*256 +: 256], t.data[k*256 +: 256]);
          end else if (!t.err) begin
            model[t.idx] = t.data;
          end
        end
      end else if (sb.size() != 0) begin
        check("ready_in_busy", 256'(req_ready), 256'(0));
        if (cyc >= sb[0].acc + LAT - 1) begin
          check("resp_timeout", 256'(0), 256'(1));
          void'(sb.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        t.wr  = req_write;
        t.idx = idx_of(req_addr);
        t.err = err_of(req_addr);
        t.acc = cyc + 1;
        if (req_write)  t.data = req_wdata;
        else if (t.err) t.data = '0;
        else            t.data = model.exists(t.idx) ? model[t.idx] : 'x;
        sb.push_back(t);
      end
    end
  end

  task automatic wait_accept();
    bit hit = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (req_valid && req_ready) begin hit = 1; break; end
    end
    if (!hit) check("accept_timeout", 256'(0), 256'(1));
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 64 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", 256'(0), 256'(1));
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [BB-1:0] data);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data;
    wait_accept();
    req_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    int acc[3];
    logic [31:0] b2b_addr[3];
    b2b_addr[0] = 32'h0000_0400; b2b_addr[1] = 32'h0000_0480; b2b_addr[2] = 32'h0000_0500;

    // Reset, released mid-cycle.
    @(negedge clk);
    check("ready_during_rst", 256'(req_ready), 256'(0));
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 256'(req_ready), 256'(1));
    check("valid_after_rst", 256'(resp_valid), 256'(0));
    check("rdata_after_rst", resp_rdata[255:0], 256'(0));
    repeat (5) @(negedge clk);

    // Write then read, same block.
    do_req(1'b1, 32'h0000_0180, pat());
    do_req(1'b0, 32'h0000_0180, '0);

    // Offset bits ignored.
    do_req(1'b1, 32'h0000_0200, pat());
    do_req(1'b0, 32'h0000_027F, '0);

    // Back-to-back reads with req_valid held; addr scrambled during BUSY.
    for (int i = 0; i < 3; i++) do_req(1'b1, b2b_addr[i], pat());
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = b2b_addr[0];
    for (int i = 0; i < 3; i++) begin
      wait_accept();
      acc[i] = cyc;
      req_addr = 32'h0000_0600 + 32'(i) * 32'h80;
      if (i < 2) begin
        @(posedge clk); #1;
        req_addr = b2b_addr[i+1];
      end
    end
    req_valid = 1'b0;
    wait_drain();
    check("b2b_spacing_01", 256'(acc[1] - acc[0]), 256'(LAT + 1));
    check("b2b_spacing_12", 256'(acc[2] - acc[1]), 256'(LAT + 1));

    // Reset two cycles into a write drops it.
    do_req(1'b1, 32'h0000_0080, pat());
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0080; req_wdata = pat();
    wait_accept();
    req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("rdata_after_midrst", resp_rdata[255:0], 256'(0));
    check("ready_after_midrst", 256'(req_ready), 256'(1));
    repeat (LAT + 2) @(negedge clk);
    do_req(1'b0, 32'h0000_0080, '0);

    // Upper address bits: range error or aliasing depending on build.
    do_req(1'b1, 32'h0000_0000, pat());
    do_req(1'b0, 32'h0000_8000, '0);
    do_req(1'b1, 32'h0000_8000, pat());
    do_req(1'b0, 32'h0000_0000, '0);

    // Idle stretch: any response here is spurious.
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule
